// File: rtl/ccw_router_pkg.sv
// Shared constants and types for the counter-clockwise router link.
package ccw_router_pkg;

   localparam int DATA_WIDTH = 64;
   localparam int HOP_MSB    = 55;
   localparam int HOP_LSB    = 48;

   localparam logic VC_EVEN = 1'b0;
   localparam logic VC_ODD  = 1'b1;

   // Which requester a slot's round-robin currently favours.
   typedef enum logic {
      SRC_CCW = 1'b0,
      SRC_PE  = 1'b1
   } src_e;

endpackage

// File: rtl/ccw_vc_slot.sv
// One virtual-channel slot: two-way round-robin arbiter (ccw vs PE) feeding a
// one-deep packet buffer that is emptied by the send strobe from the top.
module ccw_vc_slot #(
   parameter int DATA_WIDTH = ccw_router_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req_ccw,
   input  logic                  i_req_pe,
   input  logic [DATA_WIDTH-1:0] i_data_ccw,
   input  logic [DATA_WIDTH-1:0] i_data_pe,
   input  logic                  i_send,
   output logic                  o_grant_ccw,
   output logic                  o_grant_pe,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data
);
   import ccw_router_pkg::*;

   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_data;
   src_e                  r_prio;

   logic w_free;
   logic w_win_ccw;
   logic w_win_pe;

   // Winners drive capture ungated; reset only masks the visible grants, so the
   // async reset net never reaches a flop D input.
   always_comb begin
      w_free    = ~r_valid;
      w_win_ccw = w_free & i_req_ccw & (~i_req_pe  | (r_prio == SRC_CCW));
      w_win_pe  = w_free & i_req_pe  & (~i_req_ccw | (r_prio == SRC_PE));
   end

   assign o_grant_ccw = w_win_ccw & rst;
   assign o_grant_pe  = w_win_pe  & rst;

   // NOTE: the data register is reset too so ccwdo and the buffer come out of
   // reset at a known zero, not whatever the last packet left behind.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_prio  <= SRC_CCW;
      end else if (w_win_ccw) begin
         r_valid <= 1'b1;
         r_data  <= i_data_ccw;
         r_prio  <= SRC_PE;
      end else if (w_win_pe) begin
         r_valid <= 1'b1;
         r_data  <= i_data_pe;
         r_prio  <= SRC_CCW;
      end else if (i_send) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/ccw_output_buffer.sv
// Counter-clockwise output stage: even/odd VC slots, polarity-driven send mux
// and registered link outputs. Optional hop decrement: CCW_OUTPUT_HOP_UPDATE_EN.
module ccw_output_buffer #(
   parameter int DATA_WIDTH = ccw_router_pkg::DATA_WIDTH,
   parameter int HOP_MSB    = ccw_router_pkg::HOP_MSB,
   parameter int HOP_LSB    = ccw_router_pkg::HOP_LSB
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  polarity,
   input  logic                  req_ccw_even,
   input  logic                  req_ccw_odd,
   input  logic [DATA_WIDTH-1:0] data_ccw_even,
   input  logic [DATA_WIDTH-1:0] data_ccw_odd,
   input  logic                  req_pe_even,
   input  logic                  req_pe_odd,
   input  logic [DATA_WIDTH-1:0] data_pe_even,
   input  logic [DATA_WIDTH-1:0] data_pe_odd,
   output logic                  grant_ccw_even,
   output logic                  grant_ccw_odd,
   output logic                  grant_pe_even,
   output logic                  grant_pe_odd,
   input  logic                  ccwro,
   output logic                  ccwso,
   output logic [DATA_WIDTH-1:0] ccwdo
);
   import ccw_router_pkg::*;

   logic                  w_valid [2];
   logic [DATA_WIDTH-1:0] w_data  [2];
   logic                  w_send  [2];
   logic                  w_cand;
   logic                  w_send_any;
   logic [DATA_WIDTH-1:0] w_cand_data;
   logic [DATA_WIDTH-1:0] w_link_data;

   logic                  r_ccwso;
   logic [DATA_WIDTH-1:0] r_ccwdo;

   ccw_vc_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot_even (
      .clk         (clk),
      .rst         (rst),
      .i_req_ccw   (req_ccw_even),
      .i_req_pe    (req_pe_even),
      .i_data_ccw  (data_ccw_even),
      .i_data_pe   (data_pe_even),
      .i_send      (w_send[VC_EVEN]),
      .o_grant_ccw (grant_ccw_even),
      .o_grant_pe  (grant_pe_even),
      .o_valid     (w_valid[VC_EVEN]),
      .o_data      (w_data[VC_EVEN])
   );

   ccw_vc_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot_odd (
      .clk         (clk),
      .rst         (rst),
      .i_req_ccw   (req_ccw_odd),
      .i_req_pe    (req_pe_odd),
      .i_data_ccw  (data_ccw_odd),
      .i_data_pe   (data_pe_odd),
      .i_send      (w_send[VC_ODD]),
      .o_grant_ccw (grant_ccw_odd),
      .o_grant_pe  (grant_pe_odd),
      .o_valid     (w_valid[VC_ODD]),
      .o_data      (w_data[VC_ODD])
   );

   // Send the slot whose packet will land in the downstream's opposite phase.
   always_comb begin
      w_cand           = polarity ? VC_EVEN : VC_ODD;
      w_cand_data      = w_data[w_cand];
      w_send_any       = w_valid[w_cand] & ccwro;
      w_send[VC_EVEN]  = w_send_any & (w_cand == VC_EVEN);
      w_send[VC_ODD]   = w_send_any & (w_cand == VC_ODD);
   end

   always_comb begin
      w_link_data = w_cand_data;
`ifdef CCW_OUTPUT_HOP_UPDATE_EN
      w_link_data[HOP_MSB:HOP_LSB] = w_cand_data[HOP_MSB:HOP_LSB] >> 1;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ccwso <= 1'b0;
         r_ccwdo <= '0;
      end else begin
         r_ccwso <= w_send_any;
         if (w_send_any) begin
            r_ccwdo <= w_link_data;
         end
      end
   end

   assign ccwso = r_ccwso;
   assign ccwdo = r_ccwdo;

endmodule

// File: tb/tb_ccw_output_buffer.sv
// Randomized bench for ccw_output_buffer with a per-VC reference model.
module tb_ccw_output_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        polarity = 1'b0;
   logic        req_ccw_even = 1'b0, req_ccw_odd = 1'b0;
   logic        req_pe_even = 1'b0, req_pe_odd = 1'b0;
   logic [63:0] data_ccw_even = '0, data_ccw_odd = '0;
   logic [63:0] data_pe_even = '0, data_pe_odd = '0;
   logic        grant_ccw_even, grant_ccw_odd, grant_pe_even, grant_pe_odd;
   logic        ccwro = 1'b0;
   logic        ccwso;
   logic [63:0] ccwdo;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // Reference model: per-VC buffer contents, and who won the last arbitration.
   bit          m_full     [2];
   logic [63:0] m_pkt      [2];
   bit          m_ccw_last [2];
   bit          m_so;
   logic [63:0] m_do;

   ccw_output_buffer dut (
      .clk            (clk),
      .rst            (rst),
      .polarity       (polarity),
      .req_ccw_even   (req_ccw_even),
      .req_ccw_odd    (req_ccw_odd),
      .data_ccw_even  (data_ccw_even),
      .data_ccw_odd   (data_ccw_odd),
      .req_pe_even    (req_pe_even),
      .req_pe_odd     (req_pe_odd),
      .data_pe_even   (data_pe_even),
      .data_pe_odd    (data_pe_odd),
      .grant_ccw_even (grant_ccw_even),
      .grant_ccw_odd  (grant_ccw_odd),
      .grant_pe_even  (grant_pe_even),
      .grant_pe_odd   (grant_pe_odd),
      .ccwro          (ccwro),
      .ccwso          (ccwso),
      .ccwdo          (ccwdo)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s (cycle %0d): got %h, expected %h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [63:0] link_of(input logic [63:0] d);
      logic [63:0] r;
      r = d;
`ifdef CCW_OUTPUT_HOP_UPDATE_EN
      r[55:48] = d[55:48] / 2;
`endif
      return r;
   endfunction

   task automatic model_reset();
      for (int v = 0; v < 2; v++) begin
         m_full[v]     = 0;
         m_pkt[v]      = '0;
         m_ccw_last[v] = 0;
      end
      m_so = 0;
      m_do = '0;
   endtask

   // Called right after inputs are driven at a negedge: checks grants, then the
   // following posedge's link outputs.
   task automatic cycle();
      bit          rc [2], rp [2], gc [2], gp [2];
      logic [63:0] dc [2], dp [2];
      int          cand;
      bit          snd;
      #1;
      rc[0] = req_ccw_even; rc[1] = req_ccw_odd;
      rp[0] = req_pe_even;  rp[1] = req_pe_odd;
      dc[0] = data_ccw_even; dc[1] = data_ccw_odd;
      dp[0] = data_pe_even;  dp[1] = data_pe_odd;
      for (int v = 0; v < 2; v++) begin
         gc[v] = 0;
         gp[v] = 0;
         if (rst && !m_full[v]) begin
            if (rc[v] && rp[v]) begin
               if (m_ccw_last[v]) gp[v] = 1;
               else gc[v] = 1;
            end else begin
               gc[v] = rc[v];
               gp[v] = rp[v];
            end
         end
      end
      check("grant_ccw_even", grant_ccw_even, gc[0]);
      check("grant_pe_even",  grant_pe_even,  gp[0]);
      check("grant_ccw_odd",  grant_ccw_odd,  gc[1]);
      check("grant_pe_odd",   grant_pe_odd,   gp[1]);
      cand = polarity ? 0 : 1;
      snd  = m_full[cand] && ccwro;
      @(posedge clk);
      #1;
      cyc++;
      if (snd) begin
         m_so = 1;
         m_do = link_of(m_pkt[cand]);
         m_full[cand] = 0;
      end else begin
         m_so = 0;
      end
      for (int v = 0; v < 2; v++) begin
         if (gc[v] || gp[v]) begin
            m_full[v]     = 1;
            m_pkt[v]      = gc[v] ? dc[v] : dp[v];
            m_ccw_last[v] = gc[v];
         end
      end
      check("ccwso", ccwso, m_so);
      check("ccwdo", ccwdo, m_do);
   endtask

   task automatic drive_random();
      polarity      = 1'($urandom_range(0, 1));
      ccwro         = ($urandom_range(0, 3) != 0);
      req_ccw_even  = 1'($urandom_range(0, 1));
      req_ccw_odd   = 1'($urandom_range(0, 1));
      req_pe_even   = 1'($urandom_range(0, 1));
      req_pe_odd    = 1'($urandom_range(0, 1));
      data_ccw_even = {$urandom, $urandom};
      data_ccw_odd  = {$urandom, $urandom};
      data_pe_even  = {$urandom, $urandom};
      data_pe_odd   = {$urandom, $urandom};
   endtask

   task automatic clear_reqs();
      req_ccw_even = 0; req_ccw_odd = 0; req_pe_even = 0; req_pe_odd = 0;
   endtask

   initial begin : main
      logic [63:0] exp_fwd;
      bit          exp_ccw;
      int          n_alt;
`ifdef CCW_OUTPUT_HOP_UPDATE_EN
      exp_fwd = 64'h007F_0000_0000_00AA;
`else
      exp_fwd = 64'h00FF_0000_0000_00AA;
`endif
      model_reset();

      // Reset: grants held low even with every request up.
      req_ccw_even = 1; req_ccw_odd = 1; req_pe_even = 1; req_pe_odd = 1;
      #2;
      check("rst_ccwso", ccwso, 1'b0);
      check("rst_ccwdo", ccwdo, 64'h0);
      check("rst_gce", grant_ccw_even, 1'b0);
      check("rst_gpo", grant_pe_odd, 1'b0);

      // Single forward, requested in the cycle reset releases.
      @(negedge clk);
      rst = 1; clear_reqs();
      req_ccw_even = 1; data_ccw_even = 64'h00FF_0000_0000_00AA;
      polarity = 0; ccwro = 1;
      #1 check("fwd_grant", grant_ccw_even, 1'b1);
      cycle();
      @(negedge clk);
      req_ccw_even = 0; polarity = 1;
      cycle();
      check("fwd_ccwso", ccwso, 1'b1);
      check("fwd_ccwdo", ccwdo, exp_fwd);

      // Contention on the odd VC: winners alternate, starting with ccw.
      exp_ccw = 1; n_alt = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         polarity = i[0]; ccwro = 1;
         req_ccw_odd = 1; req_pe_odd = 1;
         data_ccw_odd = {$urandom, $urandom};
         data_pe_odd  = {$urandom, $urandom};
         #1;
         if (grant_ccw_odd || grant_pe_odd) begin
            check("alt_winner", grant_ccw_odd, exp_ccw);
            exp_ccw = !exp_ccw;
            n_alt++;
         end
         cycle();
      end
      check("alt_count", (n_alt >= 4), 1'b1);

      // Backpressure on the odd VC, then release.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         clear_reqs(); req_ccw_odd = 1; data_ccw_odd = {$urandom, $urandom};
         polarity = i[0]; ccwro = 0;
         cycle();
      end
      check("bp_full", ccwso, 1'b0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         polarity = i[0]; ccwro = 1; data_ccw_odd = {$urandom, $urandom};
         cycle();
      end

      // Interleave: both VCs loaded, polarity toggling every cycle.
      @(negedge clk);
      clear_reqs(); req_ccw_even = 1; req_pe_odd = 1; ccwro = 0;
      cycle();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         polarity = i[0]; ccwro = 1;
         data_ccw_even = {$urandom, $urandom};
         data_pe_odd   = {$urandom, $urandom};
         cycle();
      end

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         drive_random();
         cycle();
      end

      // Reset mid-operation with buffered packets.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive_random(); ccwro = 0;
         cycle();
      end
      @(negedge clk);
      req_ccw_even = 1; req_ccw_odd = 1; req_pe_even = 1; req_pe_odd = 1;
      ccwro = 1; polarity = 0;
      #2 rst = 0;
      #1;
      model_reset();
      check("mid_rst_ccwso", ccwso, 1'b0);
      check("mid_rst_ccwdo", ccwdo, 64'h0);
      check("mid_rst_gco", grant_ccw_odd, 1'b0);
      check("mid_rst_gpe", grant_pe_even, 1'b0);
      @(posedge clk);
      #1 check("mid_rst_no_send", ccwso, 1'b0);
      @(negedge clk);
      rst = 1; clear_reqs(); req_pe_odd = 1; data_pe_odd = {$urandom, $urandom};
      #1 check("post_rst_grant", grant_pe_odd, 1'b1);
      cycle();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         drive_random();
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
